parity_job_control: RTL

PARITY_JOB_CONTROL -- requirements
Module: parity_job_control

---
 rtl/parity_job_control.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/parity_job_control.sv
// Job control front end: parity-checked START/RESET commands drive the
// work element through reset, priming, running and a one-cycle finish.
module parity_job_control #(
    parameter logic [7:0]  DONE_TAG       = 8'h04,
    parameter int unsigned RESET_HOLD     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        job_valid,
    input  logic [7:0]  job_command,
    input  logic        job_command_parity,
    input  logic [63:0] job_address,
    input  logic        job_address_parity,
    input  logic        response_valid,
    input  logic [7:0]  response_tag,
    input  logic [7:0]  response_code,
    output logic        job_running,
    output logic        job_done,
    output logic [63:0] job_error,
    output logic        job_cack,
    output logic        job_yield,
    output logic        we_reset,
    output logic        we_enabled,
    output logic [63:0] we_wed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESETTING,
        S_PRIMING,
        S_RUNNING,
        S_FINISH
    } state_t;

    localparam logic [7:0]  CMD_START = 8'h90;
    localparam logic [7:0]  CMD_RESET = 8'h80;
    localparam logic [7:0]  HOLD_LOAD = 8'(RESET_HOLD - 1);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_hold;
    logic [31:0] r_cnt;
    logic        r_running;
    logic        r_done;
    logic        r_we_reset;
    logic [63:0] r_error;
    logic [63:0] r_wed;

    logic        w_cmd_ok;
    logic        w_adr_ok;
    logic        w_start;
    logic        w_rst_cmd;
    logic        w_done_rsp;
    logic        w_err_load;
    logic [63:0] w_err_val;
    logic        w_wed_load;

    assign w_cmd_ok   = job_command_parity == ~^job_command;
    assign w_adr_ok   = job_address_parity == ~^job_address;
    assign w_start    = job_valid && (job_command == CMD_START);
    assign w_rst_cmd  = job_valid && (job_command == CMD_RESET);
    assign w_done_rsp = response_valid && (response_tag == DONE_TAG);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_load = 1'b0;
        w_err_val  = 64'd0;
        w_wed_load = 1'b0;
        if (w_rst_cmd) begin
            w_next     = S_RESETTING;
            w_err_load = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (!w_cmd_ok) begin
                            w_next     = S_FINISH;
                            w_err_load = 1'b1;
                            w_err_val  = 64'd1;
                        end else if (!w_adr_ok) begin
                            w_next     = S_FINISH;
                            w_err_load = 1'b1;
                            w_err_val  = 64'd2;
                        end else begin
                            w_next     = S_PRIMING;
                            w_wed_load = 1'b1;
                        end
                    end
                end
                S_RESETTING: begin
                    if (r_hold == 8'd0) begin
                        w_next = S_FINISH;
                    end
                end
                S_PRIMING: begin
                    w_next = S_RUNNING;
                end
                S_RUNNING: begin
                    // a matching completion outranks a same-cycle timeout
                    if (w_done_rsp) begin
                        w_next     = S_FINISH;
                        w_err_load = 1'b1;
                        w_err_val  = (response_code == 8'h00) ? 64'd0 : 64'd3;
                    end else if (r_cnt == TMO_LIMIT) begin
                        w_next     = S_FINISH;
                        w_err_load = 1'b1;
                        w_err_val  = 64'd4;
                    end
                end
                S_FINISH: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold     <= 8'd0;
            r_cnt      <= 32'd0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_we_reset <= 1'b1;
            r_error    <= 64'd0;
            r_wed      <= 64'd0;
        end else begin
            if (w_rst_cmd) begin
                r_hold <= HOLD_LOAD;
            end else if (r_state == S_RESETTING && r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
            end
            // zero outside RUNNING, so it starts from 0 on entry
            if (r_state == S_RUNNING) begin
                r_cnt <= r_cnt + 32'd1;
            end else begin
                r_cnt <= 32'd0;
            end
            r_running  <= w_next == S_RUNNING;
            r_we_reset <= w_next != S_RUNNING;
            r_done     <= w_next == S_FINISH;
            if (w_err_load) begin
                r_error <= w_err_val;
            end
            if (w_wed_load) begin
                r_wed <= job_address;
            end
        end
    end

    assign job_running = r_running;
    assign we_enabled  = r_running;
    assign we_reset    = r_we_reset;
    assign job_done    = r_done;
    assign job_error   = r_error;
    assign we_wed      = r_wed;
    assign job_cack    = 1'b0;
    assign job_yield   = 1'b0;

endmodule
